pll_ddr3_seq: RTL and testbench

Bring-up and supervision sequencer for the DDR3 PLL. It holds the PLL in reset, waits for lock with a timeout and bounded retries, and requires lock to stay stable for a set period. It then enables the two gated PLL outputs in order, and finally releases the DDR3 controller reset. It runs on the free-running init clock, sits beside the PLL wrapper, and drives the wrapper's reset and enclk inputs.

---
 rtl/pll_ddr3_seq.sv | 147 ++++++++++++++
 tb/tb_pll_ddr3_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_ddr3_seq.sv
// DDR3 PLL bring-up sequencer: holds the PLL in reset, waits for a stable lock with bounded
// retries, enables the gated PLL outputs in order, then releases the DDR3 controller reset.
module pll_ddr3_seq #(
   parameter int RST_HOLD      = 64,
   parameter int LOCK_TIMEOUT  = 100000,
   parameter int STABLE_CYCLES = 1024,
   parameter int ENCLK_GAP     = 16,
   parameter int MAX_RETRY     = 3,
   parameter int CNT_W         = 20
) (
   input  logic       init_clk,
   input  logic       resetn,
   input  logic       pll_lock,
   input  logic       relock_req,
   output logic       pll_rst,
   output logic       enclk0,
   output logic       enclk2,
   output logic       ddr_rst_n,
   output logic       ready,
   output logic       fail,
   output logic [1:0] retry_cnt,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_RESET_HOLD = 3'd0,
      S_WAIT_LOCK  = 3'd1,
      S_STABLE     = 3'd2,
      S_EN_CLK0    = 3'd3,
      S_EN_CLK2    = 3'd4,
      S_RUN        = 3'd5,
      S_FAIL       = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_HOLD - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(ENCLK_GAP - 1);
   localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRY);

   state_t           cur;
   state_t           nxt;
   state_t           retry_state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       nxt_retry;
   logic [1:0]       retry_next_val;
   logic [1:0]       sync_q;
   logic             lock_s;
   logic             at_max;

   // pll_lock is asynchronous to init_clk; two flops before anything decodes it.
   always_ff @(posedge init_clk or negedge resetn) begin
      if (!resetn) sync_q <= 2'b00;
      else         sync_q <= {sync_q[0], pll_lock};
   end

   assign lock_s = sync_q[1];

   // A failed attempt either retries from RESET_HOLD or gives up once the budget is spent.
   assign at_max         = (retry_cnt == RETRY_MAX);
   assign retry_state    = at_max ? S_FAIL : S_RESET_HOLD;
   assign retry_next_val = at_max ? retry_cnt : retry_cnt + 2'd1;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      nxt       = cur;
      nxt_retry = retry_cnt;
      unique case (cur)
         S_RESET_HOLD: if (cnt == RST_LAST) nxt = S_WAIT_LOCK;
         S_WAIT_LOCK: begin
            if (lock_s) nxt = S_STABLE;
            else if (cnt == TIMEOUT_LAST) begin
               nxt       = retry_state;
               nxt_retry = retry_next_val;
            end
         end
         S_STABLE: begin
            if (!lock_s)                  nxt = S_WAIT_LOCK;
            else if (cnt == STABLE_LAST)  nxt = S_EN_CLK0;
         end
         S_EN_CLK0: begin
            if (!lock_s) begin
               nxt       = retry_state;
               nxt_retry = retry_next_val;
            end else if (cnt == GAP_LAST) nxt = S_EN_CLK2;
         end
         S_EN_CLK2: begin
            if (!lock_s) begin
               nxt       = retry_state;
               nxt_retry = retry_next_val;
            end else if (cnt == GAP_LAST) begin
               nxt       = S_RUN;
               nxt_retry = 2'd0;
            end
         end
         S_RUN: begin
            // An explicit relock outranks a coincident lock loss.
            if (relock_req) begin
               nxt       = S_RESET_HOLD;
               nxt_retry = 2'd0;
            end else if (!lock_s) begin
               nxt       = retry_state;
               nxt_retry = retry_next_val;
            end
         end
         S_FAIL: begin
            if (relock_req) begin
               nxt       = S_RESET_HOLD;
               nxt_retry = 2'd0;
            end
         end
         default: begin
            nxt       = S_RESET_HOLD;
            nxt_retry = 2'd0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; outputs are decoded from
   // the next state so they are registered yet change on the same edge as the state.
   always_ff @(posedge init_clk or negedge resetn) begin
      if (!resetn) begin
         cur       <= S_RESET_HOLD;
         cnt       <= '0;
         retry_cnt <= 2'd0;
         pll_rst   <= 1'b1;
         enclk0    <= 1'b0;
         enclk2    <= 1'b0;
         ddr_rst_n <= 1'b0;
         ready     <= 1'b0;
         fail      <= 1'b0;
      end else begin
         cur       <= nxt;
         cnt       <= (nxt != cur) ? '0 : cnt + CNT_W'(1);
         retry_cnt <= nxt_retry;
         pll_rst   <= (nxt == S_RESET_HOLD) || (nxt == S_FAIL);
         enclk0    <= (nxt == S_EN_CLK0) || (nxt == S_EN_CLK2) || (nxt == S_RUN);
         enclk2    <= (nxt == S_EN_CLK2) || (nxt == S_RUN);
         ddr_rst_n <= (nxt == S_RUN);
         ready     <= (nxt == S_RUN);
         fail      <= (nxt == S_FAIL);
      end
   end

   assign state = cur;

endmodule

// File: tb/tb_pll_ddr3_seq.sv
// Scoreboard bench for pll_ddr3_seq: stimulus queues each expected state transition with its
// dwell time and retry count; a negedge monitor pops and compares on every observed transition.
module tb_pll_ddr3_seq;

   localparam int RST_HOLD      = 4;
   localparam int LOCK_TIMEOUT  = 20;
   localparam int STABLE_CYCLES = 8;
   localparam int ENCLK_GAP     = 2;
   localparam int MAX_RETRY     = 2;

   localparam logic [2:0] S_RH = 3'd0, S_WL = 3'd1, S_ST = 3'd2, S_E0 = 3'd3,
                          S_E2 = 3'd4, S_RUN = 3'd5, S_FAIL = 3'd6;

   typedef struct {
      logic [2:0] st;
      int         dwell;   // cycles spent in the previous state; -1 means not checked
      logic [1:0] retry;
   } exp_t;

   exp_t  exp_q[$];
   int    checks   = 0;
   int    failures = 0;
   string phase    = "init";

   logic       init_clk   = 1'b0;
   logic       resetn     = 1'b0;
   logic       pll_lock   = 1'b0;
   logic       relock_req = 1'b0;
   logic       pll_rst, enclk0, enclk2, ddr_rst_n, ready, fail;
   logic [1:0] retry_cnt;
   logic [2:0] state;

   always #5 init_clk = ~init_clk;

   pll_ddr3_seq #(
      .RST_HOLD(RST_HOLD), .LOCK_TIMEOUT(LOCK_TIMEOUT), .STABLE_CYCLES(STABLE_CYCLES),
      .ENCLK_GAP(ENCLK_GAP), .MAX_RETRY(MAX_RETRY), .CNT_W(20)
   ) dut (
      .init_clk(init_clk), .resetn(resetn), .pll_lock(pll_lock), .relock_req(relock_req),
      .pll_rst(pll_rst), .enclk0(enclk0), .enclk2(enclk2), .ddr_rst_n(ddr_rst_n),
      .ready(ready), .fail(fail), .retry_cnt(retry_cnt), .state(state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s/%s: got %0d expected %0d at %0t", phase, name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      failures++;
      $display("FAIL %s/%s at %0t", phase, name, $time);
   endtask

   // {pll_rst, enclk0, enclk2, ddr_rst_n, ready, fail} for each state
   function automatic logic [5:0] exp_outs(input logic [2:0] s);
      case (s)
         S_RH:    return 6'b100000;
         S_E0:    return 6'b010000;
         S_E2:    return 6'b011000;
         S_RUN:   return 6'b011110;
         S_FAIL:  return 6'b100001;
         default: return 6'b000000;
      endcase
   endfunction

   task automatic push(input logic [2:0] st, input int dwell, input logic [1:0] retry);
      exp_t e;
      e.st    = st;
      e.dwell = dwell;
      e.retry = retry;
      exp_q.push_back(e);
   endtask

   // Nominal bring-up from RESET_HOLD (entered with retry r) through to RUN.
   task automatic push_bringup(input int rh_dwell, input logic [1:0] r);
      push(S_RH, rh_dwell, r);
      push(S_WL, RST_HOLD, r);
      push(S_ST, 7, r);
      push(S_E0, STABLE_CYCLES, r);
      push(S_E2, ENCLK_GAP, r);
      push(S_RUN, ENCLK_GAP, 2'd0);
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget);
      int n = 0;
      do begin
         @(negedge init_clk);
         n++;
      end while (state !== s && n < budget);
      if (state !== s) flag($sformatf("timeout waiting for state %0d", s));
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge init_clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         flag($sformatf("scoreboard not drained, %0d left", exp_q.size()));
         exp_q.delete();
      end
   endtask

   // PLL model: lock rises on the 5th negedge that sees pll_rst low.
   task automatic raise_lock(input int n);
      int k = 0;
      do begin
         @(negedge init_clk);
         k++;
      end while (pll_rst !== 1'b0 && k < 100);
      if (pll_rst !== 1'b0) flag("timeout waiting for pll_rst low");
      repeat (n - 1) @(negedge init_clk);
      pll_lock = 1'b1;
   endtask

   task automatic pulse_relock();
      relock_req = 1'b1;
      @(negedge init_clk);
      relock_req = 1'b0;
   endtask

   // Monitor: every state change pops one expected transition.
   initial begin
      logic [2:0] prev;
      int         dwell;
      exp_t       e;
      prev  = S_RH;
      dwell = 0;
      forever begin
         @(negedge init_clk);
         if (!resetn) begin
            prev  = S_RH;
            dwell = 0;
         end else begin
            dwell++;
            if (state !== prev) begin
               if (exp_q.size() == 0) begin
                  flag($sformatf("unexpected transition %0d->%0d", prev, state));
               end else begin
                  e = exp_q.pop_front();
                  check("state", state, e.st);
                  if (e.dwell >= 0) check("dwell", dwell, e.dwell);
                  check("retry_cnt", retry_cnt, e.retry);
                  check("outputs", {pll_rst, enclk0, enclk2, ddr_rst_n, ready, fail},
                        exp_outs(e.st));
               end
               prev  = state;
               dwell = 0;
            end
         end
      end
   end

   initial begin
      phase = "reset";
      repeat (2) @(negedge init_clk);
      check("state", state, S_RH);
      check("outputs", {pll_rst, enclk0, enclk2, ddr_rst_n, ready, fail}, 6'b100000);
      check("retry_cnt", retry_cnt, 0);

      // Lock never comes: three 4+20 attempts, FAIL on the 72nd cycle after release.
      phase = "no_lock";
      push(S_WL, RST_HOLD, 2'd0);
      push(S_RH, LOCK_TIMEOUT, 2'd1);
      push(S_WL, RST_HOLD, 2'd1);
      push(S_RH, LOCK_TIMEOUT, 2'd2);
      push(S_WL, RST_HOLD, 2'd2);
      push(S_FAIL, LOCK_TIMEOUT, 2'd2);
      #1 resetn = 1'b1;
      wait_state(S_FAIL, 150);
      repeat (5) @(negedge init_clk);
      check("fail_held", {state, fail}, {S_FAIL, 1'b1});
      wait_drain(5);

      // relock_req from FAIL restarts with retry_cnt=0; nominal bring-up timing.
      phase = "nominal";
      push_bringup(-1, 2'd0);
      pulse_relock();
      raise_lock(5);
      wait_state(S_RUN, 100);
      wait_drain(5);

      // Lock loss in RUN: drop visible on the third edge after the raw pin falls.
      phase = "loss_in_run";
      repeat (3) @(negedge init_clk);
      push_bringup(-1, 2'd1);
      pll_lock = 1'b0;
      @(negedge init_clk);
      check("still_run_1", state, S_RUN);
      @(negedge init_clk);
      check("still_run_2", {state, ready}, {S_RUN, 1'b1});
      @(negedge init_clk);
      check("loss_state", state, S_RH);
      check("loss_outputs", {pll_rst, enclk0, enclk2, ddr_rst_n, ready, fail}, 6'b100000);
      check("loss_retry", retry_cnt, 1);
      raise_lock(5);
      wait_state(S_RUN, 100);
      wait_drain(5);

      // relock_req coinciding with lock loss in RUN: relock wins, retry_cnt stays 0.
      // Then a one-cycle lock_s glitch at STABLE counter=5 sends it back to WAIT_LOCK.
      phase = "relock_vs_loss";
      push(S_RH, -1, 2'd0);
      push(S_WL, RST_HOLD, 2'd0);
      push(S_ST, 7, 2'd0);
      push(S_WL, 6, 2'd0);
      push(S_ST, 1, 2'd0);
      push(S_E0, STABLE_CYCLES, 2'd0);
      push(S_E2, ENCLK_GAP, 2'd0);
      push(S_RUN, ENCLK_GAP, 2'd0);
      pll_lock = 1'b0;
      repeat (2) @(negedge init_clk);
      pulse_relock();
      check("relock_priority", {state, 1'b0, retry_cnt}, {S_RH, 3'd0});
      phase = "glitch";
      raise_lock(5);
      wait_state(S_ST, 50);
      repeat (3) @(negedge init_clk);
      pll_lock = 1'b0;
      @(negedge init_clk);
      pll_lock = 1'b1;
      wait_state(S_RUN, 100);
      wait_drain(5);

      // Lock_s rises exactly when WAIT_LOCK counter hits 19: lock wins, no retry.
      // relock_req in STABLE is ignored.
      phase = "lock_at_timeout";
      push(S_RH, -1, 2'd0);
      push(S_WL, RST_HOLD, 2'd0);
      push(S_ST, LOCK_TIMEOUT, 2'd0);
      push(S_E0, STABLE_CYCLES, 2'd0);
      push(S_E2, ENCLK_GAP, 2'd0);
      push(S_RUN, ENCLK_GAP, 2'd0);
      pll_lock = 1'b0;
      pulse_relock();
      wait_state(S_WL, 50);
      repeat (17) @(negedge init_clk);
      pll_lock = 1'b1;
      wait_state(S_ST, 50);
      @(negedge init_clk);
      pulse_relock();
      @(negedge init_clk);
      check("relock_ignored", state, S_ST);
      wait_state(S_RUN, 100);
      wait_drain(5);

      // resetn pulsed low in EN_CLK2: enables drop without a clock edge, then full replay.
      phase = "async_reset";
      push(S_RH, -1, 2'd0);
      push(S_WL, RST_HOLD, 2'd0);
      push(S_ST, 7, 2'd0);
      push(S_E0, STABLE_CYCLES, 2'd0);
      push(S_E2, ENCLK_GAP, 2'd0);
      pll_lock = 1'b0;
      pulse_relock();
      raise_lock(5);
      wait_state(S_E2, 100);
      check("pre_reset_enables", {enclk0, enclk2}, 2'b11);
      #3 resetn = 1'b0;
      #1;
      check("async_enables", {enclk0, enclk2}, 2'b00);
      check("async_pll_rst", pll_rst, 1);
      check("async_state", state, S_RH);
      pll_lock = 1'b0;
      wait_drain(2);
      phase = "replay";
      push(S_WL, RST_HOLD, 2'd0);
      push(S_ST, 7, 2'd0);
      push(S_E0, STABLE_CYCLES, 2'd0);
      push(S_E2, ENCLK_GAP, 2'd0);
      push(S_RUN, ENCLK_GAP, 2'd0);
      repeat (2) @(negedge init_clk);
      #1 resetn = 1'b1;
      raise_lock(5);
      wait_state(S_RUN, 100);
      wait_drain(5);
      check("final_ready", {ready, ddr_rst_n, retry_cnt}, 4'b1100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
